// File: rtl/vme_cmd_responder.sv
// VME command responder: decodes a tagged read/write command, runs one register-bus
// transaction and returns a one-cycle response. Optional bus timeout: VME_RESP_TIMEOUT_EN.
module vme_cmd_responder #(
  parameter logic [7:0] DEV_TAG        = 8'hA8,
  parameter int         TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] vme_cmd_reg,
  input  logic [31:0] vme_dat_reg_in,
  output logic        vme_cmd_rd,
  output logic        vme_dat_wr,
  output logic [31:0] vme_dat_reg_out,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_wdata,
  output logic        bus_we,
  output logic        bus_re,
  input  logic [15:0] bus_rdata,
  input  logic        bus_ack,
  output logic [15:0] cmd_count,
  output logic [15:0] err_count,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        cmd_rd_q, cmd_rd_d;
  logic        dat_wr_q, dat_wr_d;
  logic [31:0] dat_out_q, dat_out_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        rd_flag_q, rd_flag_d;
  logic        re_q, re_d;
  logic        we_q, we_d;
  logic [15:0] cmd_cnt_q, cmd_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        cmd_valid;

`ifdef VME_RESP_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_q, tmo_d;
`else
  logic [7:0] unused_tmo;
  assign unused_tmo = 8'(TIMEOUT_CYCLES);
`endif

  logic unused_bits;
  assign unused_bits = ^{vme_cmd_reg[31:26], vme_dat_reg_in[31:16]};

  // Handshake: a command is taken at any edge where start=1 and vme_cmd_rd=1;
  // vme_dat_wr is a single-cycle strobe with vme_dat_reg_out valid alongside it.
  assign cmd_valid = (vme_cmd_reg[23:16] == DEV_TAG) && (vme_cmd_reg[25] ^ vme_cmd_reg[24]);

  always_comb begin
    state_d   = state_q;
    cmd_rd_d  = cmd_rd_q;
    dat_wr_d  = 1'b0;
    dat_out_d = dat_out_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_flag_d = rd_flag_q;
    re_d      = re_q;
    we_d      = we_q;
    cmd_cnt_d = cmd_cnt_q;
    err_cnt_d = err_cnt_q;
`ifdef VME_RESP_TIMEOUT_EN
    tmo_d     = 8'd0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && cmd_rd_q) begin
          cmd_rd_d  = 1'b0;
          addr_d    = vme_cmd_reg[15:0];
          wdata_d   = vme_dat_reg_in[15:0];
          rd_flag_d = vme_cmd_reg[25];
          cmd_cnt_d = cmd_cnt_q + 16'd1;
          if (cmd_valid) begin
            state_d = S_BUS;
            re_d    = vme_cmd_reg[25];
            we_d    = vme_cmd_reg[24];
          end else begin
            state_d   = S_RESP;
            dat_wr_d  = 1'b1;
            dat_out_d = {16'hDEAD, vme_cmd_reg[15:0]};
            err_cnt_d = err_cnt_q + 16'd1;
          end
        end
      end
      S_BUS: begin
        if (bus_ack) begin
          re_d      = 1'b0;
          we_d      = 1'b0;
          state_d   = S_RESP;
          dat_wr_d  = 1'b1;
          dat_out_d = rd_flag_q ? {16'h0000, bus_rdata} : {16'h0000, wdata_q};
        end
`ifdef VME_RESP_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          re_d      = 1'b0;
          we_d      = 1'b0;
          state_d   = S_RESP;
          dat_wr_d  = 1'b1;
          dat_out_d = {16'hBEEF, addr_q};
          err_cnt_d = err_cnt_q + 16'd1;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
`endif
      end
      S_RESP: begin
        state_d  = S_IDLE;
        cmd_rd_d = 1'b1;
      end
      default: begin
        state_d  = S_IDLE;
        cmd_rd_d = 1'b1;
        re_d     = 1'b0;
        we_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cmd_rd_q  <= 1'b1;
      dat_wr_q  <= 1'b0;
      dat_out_q <= 32'd0;
      addr_q    <= 16'd0;
      wdata_q   <= 16'd0;
      rd_flag_q <= 1'b0;
      re_q      <= 1'b0;
      we_q      <= 1'b0;
      cmd_cnt_q <= 16'd0;
      err_cnt_q <= 16'd0;
`ifdef VME_RESP_TIMEOUT_EN
      tmo_q     <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      cmd_rd_q  <= cmd_rd_d;
      dat_wr_q  <= dat_wr_d;
      dat_out_q <= dat_out_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_flag_q <= rd_flag_d;
      re_q      <= re_d;
      we_q      <= we_d;
      cmd_cnt_q <= cmd_cnt_d;
      err_cnt_q <= err_cnt_d;
`ifdef VME_RESP_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign vme_cmd_rd      = cmd_rd_q;
  assign vme_dat_wr      = dat_wr_q;
  assign vme_dat_reg_out = dat_out_q;
  assign bus_addr        = addr_q;
  assign bus_wdata       = wdata_q;
  assign bus_re          = re_q;
  assign bus_we          = we_q;
  assign cmd_count       = cmd_cnt_q;
  assign err_count       = err_cnt_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_vme_cmd_responder.sv
// Bench for vme_cmd_responder: vector table, responses scoreboarded through exp_q,
// plus hand sequences for reset-in-BUS, ignored start/ack and the timeout option.
`timescale 1ns/1ps
module tb_vme_cmd_responder;

`ifdef VME_RESP_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] vme_cmd_reg = 32'd0;
  logic [31:0] vme_dat_reg_in = 32'd0;
  logic        vme_cmd_rd;
  logic        vme_dat_wr;
  logic [31:0] vme_dat_reg_out;
  logic [15:0] bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_we;
  logic        bus_re;
  logic [15:0] bus_rdata = 16'd0;
  logic        bus_ack = 1'b0;
  logic [15:0] cmd_count;
  logic [15:0] err_count;
  logic [1:0]  dbg_state;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];
  logic [15:0] exp_cmd = 16'd0;
  logic [15:0] exp_err = 16'd0;

  vme_cmd_responder #(.DEV_TAG(8'hA8), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .vme_cmd_reg(vme_cmd_reg), .vme_dat_reg_in(vme_dat_reg_in),
    .vme_cmd_rd(vme_cmd_rd), .vme_dat_wr(vme_dat_wr), .vme_dat_reg_out(vme_dat_reg_out),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .cmd_count(cmd_count), .err_count(err_count), .dbg_state(dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every response strobe pops one expected word
  logic [31:0] mon_exp;
  always @(negedge clk) begin
    if (rst_n && vme_dat_wr) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", vme_dat_reg_out, 32'hxxxxxxxx);
      end else begin
        mon_exp = exp_q.pop_front();
        check("resp_word", vme_dat_reg_out, mon_exp);
      end
    end
  end

  // Driver: issue one command, optionally ack, and check the handshake timing
  task automatic run_cmd(input logic [31:0] cmd, input logic [31:0] dat, input logic [15:0] rdata,
                         input int ack_at, input logic [31:0] exp_resp, input int exp_strobes,
                         input bit bump_err);
    int n;
    int w;
    bit is_rd;
    is_rd = cmd[25];
    w = 0;
    while (!vme_cmd_rd && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("cmd_rd_ready", {31'd0, vme_cmd_rd}, 32'd1);
    start = 1'b1;
    vme_cmd_reg = cmd;
    vme_dat_reg_in = dat;
    exp_q.push_back(exp_resp);
    exp_cmd++;
    if (bump_err) exp_err++;
    @(negedge clk);
    start = 1'b0;
    check("cmd_rd_busy", {31'd0, vme_cmd_rd}, 32'd0);
    n = 0;
    if (exp_strobes == 0) begin
      check("no_strobe", {30'd0, bus_re, bus_we}, 32'd0);
    end else begin
      while ((bus_re || bus_we) && n < 300) begin
        n++;
        check("re_we_excl", {31'd0, bus_re & bus_we}, 32'd0);
        check("strobe_kind", {31'd0, bus_re}, {31'd0, is_rd});
        check("bus_addr", {16'd0, bus_addr}, {16'd0, cmd[15:0]});
        check("bus_wdata", {16'd0, bus_wdata}, {16'd0, dat[15:0]});
        if (n == ack_at) begin
          bus_ack = 1'b1;
          bus_rdata = rdata;
        end
        @(negedge clk);
        bus_ack = 1'b0;
        bus_rdata = 16'($urandom_range(0, 65535));
      end
    end
    check("strobe_cycles", n, exp_strobes);
    check("resp_strobe", {31'd0, vme_dat_wr}, 32'd1);
    @(negedge clk);
    check("resp_one_cycle", {31'd0, vme_dat_wr}, 32'd0);
    check("cmd_rd_back", {31'd0, vme_cmd_rd}, 32'd1);
    check("resp_hold", vme_dat_reg_out, exp_resp);
    check("cmd_count", {16'd0, cmd_count}, {16'd0, exp_cmd});
    check("err_count", {16'd0, err_count}, {16'd0, exp_err});
  endtask

  typedef struct {
    logic [31:0] cmd;
    logic [31:0] dat;
    logic [15:0] rdata;
    int          ack_at;
    logic [31:0] exp_resp;
    int          exp_strobes;
    bit          bump_err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [15:0] a;
    logic [15:0] d;
    bit rd;
    int k;

    vecs[0] = '{32'h02A84100, 32'h00000000, 16'h1234, 3, 32'h00001234, 3, 1'b0};
    vecs[1] = '{32'h01A87000, 32'h000000FF, 16'h0000, 1, 32'h000000FF, 1, 1'b0};
    vecs[2] = '{32'h02B01000, 32'h00000000, 16'h0000, 0, 32'hDEAD1000, 0, 1'b1};
    vecs[3] = '{32'h03A82000, 32'h00000000, 16'h0000, 0, 32'hDEAD2000, 0, 1'b1};
    vecs[4] = '{32'h00A83333, 32'h00000000, 16'h0000, 0, 32'hDEAD3333, 0, 1'b1};
    vecs[5] = '{32'h01A8ABCD, 32'h12345678, 16'h0000, 2, 32'h00005678, 2, 1'b0};
    vecs[6] = '{32'h02A8FFFF, 32'h00000000, 16'hBEEF, 1, 32'h0000BEEF, 1, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cmd_rd", {31'd0, vme_cmd_rd}, 32'd1);
    check("rst_dat_wr", {31'd0, vme_dat_wr}, 32'd0);
    check("rst_dat_out", vme_dat_reg_out, 32'd0);
    check("rst_bus", {bus_addr, bus_wdata}, 32'd0);
    check("rst_strobes", {30'd0, bus_re, bus_we}, 32'd0);
    check("rst_counts", {cmd_count, err_count}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++)
      run_cmd(vecs[i].cmd, vecs[i].dat, vecs[i].rdata, vecs[i].ack_at,
              vecs[i].exp_resp, vecs[i].exp_strobes, vecs[i].bump_err);

    for (int i = 0; i < 6; i++) begin
      rd = 1'($urandom_range(0, 1));
      a = 16'($urandom_range(0, 65535));
      d = 16'($urandom_range(0, 65535));
      k = int'($urandom_range(1, 4));
      run_cmd({6'd0, rd, ~rd, 8'hA8, a}, {16'hFFFF, d}, d ^ 16'h5A5A, k,
              rd ? {16'h0000, d ^ 16'h5A5A} : {16'h0000, d}, k, 1'b0);
    end

`ifdef VME_RESP_TIMEOUT_EN
    run_cmd(32'h02A80010, 32'h0, 16'h0, 0, 32'hBEEF0010, 4, 1'b1);
`else
    run_cmd(32'h02A80020, 32'h0, 16'h5555, 10, 32'h00005555, 10, 1'b0);
`endif

    // bus_ack outside BUS is ignored
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    check("ack_idle_no_resp", {31'd0, vme_dat_wr}, 32'd0);
    check("ack_idle_state", {30'd0, dbg_state}, 32'd0);
    check("ack_idle_counts", {cmd_count, err_count}, {exp_cmd, exp_err});

    // Start ignored while busy, then reset with the strobe high
    start = 1'b1;
    vme_cmd_reg = 32'h02A85000;
    @(negedge clk);
    start = 1'b0;
    exp_cmd++;
    @(negedge clk);
    start = 1'b1;
    vme_cmd_reg = 32'h01A86000;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_ignored", {16'd0, cmd_count}, {16'd0, exp_cmd});
    check("busy_strobe", {30'd0, bus_re, bus_we}, 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cmd = 16'd0;
    exp_err = 16'd0;
    check("rst_bus_strobe", {30'd0, bus_re, bus_we}, 32'd0);
    check("rst_bus_no_resp", {31'd0, vme_dat_wr}, 32'd0);
    check("rst_bus_counts", {cmd_count, err_count}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("post_rst_quiet", {30'd0, vme_dat_wr, vme_cmd_rd}, 32'd1);
    end

    run_cmd(32'h01A80042, 32'h0000C0DE, 16'h0, 1, 32'h0000C0DE, 1, 1'b0);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
